// File: rtl/weak_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// weak_bus_arbiter_if
//
// Signal bundle for the two-master / one-slave weakcore bus arbiter.
// It carries both master-side ports (m0_*, m1_*) and the shared slave-side
// port (s_*).
//
// Modports:
//   master : the arbiter's view. The arbiter owns the shared slave bus, so
//            it drives s_* and the per-master response signals (in/ack/err).
//   slave  : the environment's view (the two requesters plus the slave
//            device). It drives requests, write data and the slave response.
//
// Per master x (0, 1):
//   mx_req      request, held until mx_ack
//   mx_addr     word address (bits [1:0] zero)
//   mx_wr       write enable
//   mx_wr_mask  byte-lane write mask
//   mx_out      write data
//   mx_in       read data, valid with mx_ack
//   mx_ack      transaction done, 1-cycle pulse
//   mx_err      timeout flag, only together with mx_ack
// Slave:
//   s_req, s_addr, s_wr, s_wr_mask, s_out  request towards the slave
//   s_in, s_ack                            slave response
// ---------------------------------------------------------------------------
interface weak_bus_arbiter_if;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_wr;
  logic [3:0]  m0_wr_mask;
  logic [31:0] m0_out;
  logic [31:0] m0_in;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_wr;
  logic [3:0]  m1_wr_mask;
  logic [31:0] m1_out;
  logic [31:0] m1_in;
  logic        m1_ack;
  logic        m1_err;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_wr;
  logic [3:0]  s_wr_mask;
  logic [31:0] s_out;
  logic [31:0] s_in;
  logic        s_ack;

  modport master (
    input  m0_req, m0_addr, m0_wr, m0_wr_mask, m0_out,
    output m0_in, m0_ack, m0_err,
    input  m1_req, m1_addr, m1_wr, m1_wr_mask, m1_out,
    output m1_in, m1_ack, m1_err,
    output s_req, s_addr, s_wr, s_wr_mask, s_out,
    input  s_in, s_ack
  );

  modport slave (
    output m0_req, m0_addr, m0_wr, m0_wr_mask, m0_out,
    input  m0_in, m0_ack, m0_err,
    output m1_req, m1_addr, m1_wr, m1_wr_mask, m1_out,
    input  m1_in, m1_ack, m1_err,
    input  s_req, s_addr, s_wr, s_wr_mask, s_out,
    output s_in, s_ack
  );

endinterface

// File: rtl/weak_bus_arbiter.sv
// ---------------------------------------------------------------------------
// weak_bus_arbiter
//
// Round-robin arbiter letting two weakcore-bus masters (m0: core, m1: debug
// loader / DMA) share one slave. A grant is held until the slave acks; a
// watchdog terminates transactions the slave never acknowledges, returning
// ack+err to the granted master.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles s_req may stay high without s_ack before forced
//                   termination (0 disables the watchdog), 0..65535
//
// Ports:
//   clk  clock
//   rst  synchronous reset, active-low
//   bus  weak_bus_arbiter_if.master (m0_*, m1_*, s_* signals)
//
// Timing: a request seen in IDLE is registered as a grant at the next edge;
// from then on the slave request and the master response are combinational
// from the granted master and the slave. Every transaction is followed by
// at least one IDLE cycle.
// ---------------------------------------------------------------------------
module weak_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  weak_bus_arbiter_if.master  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  localparam bit         WDOG_EN   = (TIMEOUT_CYCLES != 0);
  // Last counter value before forced termination; guarded so a disabled
  // watchdog does not underflow the constant.
  localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        prio;
  logic        prio_nxt;
  logic [15:0] wdog;

  logic        busy0;
  logic        busy1;
  logic        busy;
  logic        sel_req;
  logic        done_ok;
  logic        timeout;
  logic        abort;

  assign busy0   = (state == BUSY0);
  assign busy1   = (state == BUSY1);
  assign busy    = busy0 | busy1;
  assign sel_req = busy1 ? bus.m1_req : bus.m0_req;

  // A slave ack always wins over a coincident timeout. A granted master
  // that withdraws its request (protocol violation) is dropped silently,
  // which also takes precedence over a timeout in the same cycle.
  assign done_ok = busy & bus.s_ack;
  assign abort   = busy & ~bus.s_ack & ~sel_req;
  assign timeout = WDOG_EN & busy & ~bus.s_ack & sel_req & (wdog == WDOG_LAST);

  // Slave-side request: straight pass-through of the granted master.
  assign bus.s_req     = busy;
  assign bus.s_addr    = busy0 ? bus.m0_addr    : (busy1 ? bus.m1_addr    : 32'd0);
  assign bus.s_wr      = busy0 ? bus.m0_wr      : (busy1 ? bus.m1_wr      : 1'b0);
  assign bus.s_wr_mask = busy0 ? bus.m0_wr_mask : (busy1 ? bus.m1_wr_mask : 4'd0);
  assign bus.s_out     = busy0 ? bus.m0_out     : (busy1 ? bus.m1_out     : 32'd0);

  // Master-side response: only the granted master sees anything; read data
  // is forced to zero on a timeout so stale bus contents never leak out.
  assign bus.m0_ack = busy0 & (done_ok | timeout);
  assign bus.m0_err = busy0 & timeout;
  assign bus.m0_in  = (busy0 & ~timeout) ? bus.s_in : 32'd0;

  assign bus.m1_ack = busy1 & (done_ok | timeout);
  assign bus.m1_err = busy1 & timeout;
  assign bus.m1_in  = (busy1 & ~timeout) ? bus.s_in : 32'd0;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (bus.m0_req && (!bus.m1_req || !prio)) begin
          state_nxt = BUSY0;
        end else if (bus.m1_req) begin
          state_nxt = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (done_ok || timeout) begin
          state_nxt = IDLE;
          // Hand the tie-break to the master that was not just served.
          prio_nxt  = busy0;
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered stage: grant state, round-robin pointer and watchdog.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      wdog  <= 16'd0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      wdog  <= busy ? (wdog + 16'd1) : 16'd0;
    end
  end

endmodule

// File: doc/weak_bus_arbiter.md
Name: weak_bus_arbiter

Overview:
Two-master, one-slave arbiter for the weakcore bus protocol (req/ack/wr/wr_mask, 32-bit word bus). Master 0 is the weakcore core; master 1 is a secondary requester such as a debug loader or DMA. Both share a single memory/peripheral slave. Each transaction is locked until the slave acknowledges it. Arbitration is round-robin, and a watchdog terminates transactions the slave never acknowledges.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles s_req may stay high without s_ack before forced termination; 0 disables the watchdog; legal range 0..65535

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
m0_req  input  1  master 0 request, held until m0_ack
m0_addr  input  32  master 0 word address (bits [1:0] are zero)
m0_wr  input  1  master 0 write enable
m0_wr_mask  input  4  master 0 byte-lane write mask
m0_out  input  32  master 0 write data
m0_in  output  32  master 0 read data, valid with m0_ack
m0_ack  output  1  master 0 transaction done, 1-cycle pulse
m0_err  output  1  master 0 timeout, only asserted together with m0_ack
m1_req, m1_addr, m1_wr, m1_wr_mask, m1_out, m1_in, m1_ack, m1_err  same directions, widths and meanings for master 1
s_req  output  1  slave request
s_addr  output  32  slave address
s_wr  output  1  slave write enable
s_wr_mask  output  4  slave write mask
s_out  output  32  slave write data
s_in  input  32  slave read data, valid with s_ack
s_ack  input  1  slave done

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, prio (0 means m0 wins a tie), wdog (16-bit counter).
- Reset (rst low at a clk edge): state=IDLE, prio=0, wdog=0. Reset overrides everything, including a transaction in progress; that transaction is dropped with no ack.
- All outputs are 0 in IDLE and after reset: s_req, s_addr, s_wr, s_wr_mask, s_out, mX_ack, mX_err, mX_in.
- IDLE transitions:
  - Only m0_req high: go to BUSY0.
  - Only m1_req high: go to BUSY1.
  - Both high: go to BUSY0 if prio=0, else BUSY1.
  - Neither high: stay in IDLE.
  - wdog is cleared on every IDLE cycle.
- BUSYx outputs: s_req=1; s_addr, s_wr, s_wr_mask and s_out are driven combinationally from master x; mx_in = s_in; the other master's ack, err and in are 0.
- Latency: a request first seen in cycle t produces s_req from cycle t+1. If s_ack arrives in cycle t+1, mx_ack is high in t+1. The minimum request-to-ack time is therefore 1 cycle after the grant is registered.
- Normal ack in BUSYx (s_ack=1):
  - mx_ack=s_ack combinationally and mx_err=0.
  - Next state is IDLE; prio becomes the other master.
  - No back-to-back grant: each transaction is followed by at least one IDLE cycle.
- Watchdog in BUSYx, when TIMEOUT_CYCLES≠0 and s_ack=0:
  - wdog increments each cycle.
  - In the cycle where wdog == TIMEOUT_CYCLES-1: mx_ack=1, mx_err=1, mx_in=0. Next state is IDLE and prio flips.
  - If s_ack and the timeout coincide, the normal ack wins: err=0, data=s_in.
- Abort in BUSYx: if mx_req drops while s_ack=0 (a protocol violation), go to IDLE next cycle with no ack; prio is unchanged.
- A non-granted master's request stays pending (ack=0) until it is granted. With prio rotation, neither master waits for more than one competing transaction.
- Late slave acks: s_ack in IDLE is ignored. An ack arriving after a timeout is therefore dropped.
- Master-side write masks and addresses pass through unmodified; there is no width conversion.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with m0_req=1 -> s_req=0, m0_ack=0. Release reset -> s_req=1 next cycle with s_addr=m0_addr.
2. Single read: m0_req=1, m0_addr=0x100, slave acks 2 cycles after s_req with s_in=0x12345678 -> m0_ack pulses 1 cycle with m0_in=0x12345678, then state returns to IDLE.
3. Contention: m0 and m1 both request continuously, slave acks immediately -> grants alternate m0, m1, m0, m1, with one IDLE cycle between grants; m1 data never appears on m0_in.
4. Write pass-through: m1_req=1, m1_wr=1, m1_wr_mask=4'b1100, m1_out=0xABCD0000, m1_addr=0x204 -> s_wr=1, s_wr_mask=4'b1100, s_out=0xABCD0000, s_addr=0x204 for the whole grant.
5. Timeout with TIMEOUT_CYCLES=4, slave never acks -> m0_ack=1 and m0_err=1 in the 4th BUSY cycle with m0_in=0; s_req=0 the next cycle. A coincident s_ack in that cycle gives m0_err=0 instead.
6. Reset mid-transaction: rst=0 while in BUSY1 -> no m1_ack; s_req=0 the next cycle; prio=0, so with both masters requesting, m0 is granted first.
